// File: rtl/bpu_param_pkg.sv
// Shared types for the fetch-stage branch predictor: branch kinds, counter encodings,
// FSM states, the assembled BTB entry and the execute-stage verify bus.
package bpu_param_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BRA  = 3'd1,
    BR_J    = 3'd2,
    BR_CALL = 3'd3,
    BR_RET  = 3'd4
  } br_type_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CORRECT = 1'b1
  } bpu_state_t;

  // Tag field is sized for the widest legal tag; narrower tags are zero-extended.
  localparam int BTB_TAG_MAX = 30;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [31:0]            target;
    br_type_t               br_type;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    br_type_t    br_type;
    logic        taken;
    logic        mispredict;
    logic [1:0]  count;
  } vr_bus_t;

  // A mispredict re-seeds the counter at the weak state of the actual direction.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken,
                                          input logic mispredict);
    if (mispredict) return taken ? CNT_WT : CNT_WNT;
    if (taken) return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_param_ras.sv
// Circular return-address stack with a speculative pointer (fetch side) and a
// committed pointer (execute side); restore copies committed into speculative.
module bpu_param_ras
  import bpu_param_pkg::*;
#(
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_data,
  input  logic        commit_push,
  input  logic        commit_pop,
  input  logic        restore,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [31:0]      mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, cp_q, cp_d;
  logic [CNT_W-1:0] cnt_q, ccnt_q, ccnt_d;

  // Committed view of this cycle, so a restore includes the same-cycle commit.
  always_comb begin
    cp_d   = cp_q;
    ccnt_d = ccnt_q;
    if (commit_push) begin
      cp_d = cp_q + 1'b1;
      if (ccnt_q != FULL) ccnt_d = ccnt_q + 1'b1;
    end else if (commit_pop && (ccnt_q != '0)) begin
      cp_d   = cp_q - 1'b1;
      ccnt_d = ccnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cp_q   <= '0;
      ccnt_q <= '0;
    end else begin
      cp_q   <= cp_d;
      ccnt_q <= ccnt_d;
    end
  end

  // Overflow wraps onto the oldest slot while the count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (restore) begin
      sp_q  <= cp_d;
      cnt_q <= ccnt_d;
    end else if (push) begin
      sp_q <= sp_q + 1'b1;
      if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (pop && (cnt_q != '0)) begin
      sp_q  <= sp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !restore) mem[sp_q] <= push_data;
  end

  assign top   = mem[sp_q - 1'b1];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/bpu_param.sv
// Fetch-stage branch predictor: direct-mapped BTB + 2-bit counters, RAS, and a
// redirect FSM. Define BPU_GSHARE_EN to index counters with PC XOR global history.
module bpu_param
  import bpu_param_pkg::*;
#(
  parameter int ENTRIES   = 1024,
  parameter int TAG_W     = 20,
  parameter int RAS_DEPTH = 8,
  parameter int HIST_LEN  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush_all,
  input  logic                correct_finish,
  input  logic                if_valid,
  input  logic [31:0]         if_pc,
  output logic                pred_valid,
  output logic                pred_br_op,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic [1:0]          pred_count,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                vr_valid,
  input  logic [31:0]         vr_pc,
  input  logic [31:0]         vr_target,
  input  logic [2:0]          vr_br_type,
  input  logic                vr_taken,
  input  logic                vr_mispredict,
  input  logic [1:0]          vr_count,
  input  logic [HIST_LEN-1:0] vr_ghr,
  output logic                flush,
  output logic                corr_valid,
  output logic [31:0]         corr_target,
  output bpu_state_t          dbg_state
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Redirect handshake: corr_valid rises the cycle after an accepted mispredict and
  // holds corr_target stable until fetch pulses correct_finish (or flush_all).
  bpu_state_t state_q, state_d;
  vr_bus_t    vr;

  assign vr = '{valid: vr_valid, pc: vr_pc, target: vr_target,
                br_type: br_type_t'(vr_br_type), taken: vr_taken,
                mispredict: vr_mispredict, count: vr_count};

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];
  br_type_t           type_mem [ENTRIES];
  logic [1:0]         cnt_mem [ENTRIES];

  logic [IDX_W-1:0]    lk_idx, lk_cidx, vr_idx, vr_cidx;
  logic [TAG_W-1:0]    lk_tag, vr_tag;
  logic [HIST_LEN-1:0] cur_ghr;
  btb_entry_t          lk_ent;
  logic [1:0]          lk_cnt;
  logic                hit, lookup_go, train, restore;
  logic                p_taken;
  logic [31:0]         p_target, pc_plus8;
  logic                ras_push, ras_pop, ras_empty;
  logic [31:0]         ras_top;

  assign lk_idx   = if_pc[IDX_W+1:2];
  assign lk_tag   = if_pc[IDX_W+2 +: TAG_W];
  assign vr_idx   = vr.pc[IDX_W+1:2];
  assign vr_tag   = vr.pc[IDX_W+2 +: TAG_W];
  assign pc_plus8 = if_pc + 32'd8;

  always_comb begin
    lk_ent         = '0;
    lk_ent.valid   = valid_q[lk_idx];
    lk_ent.tag     = BTB_TAG_MAX'(tag_mem[lk_idx]);
    lk_ent.target  = tgt_mem[lk_idx];
    lk_ent.br_type = type_mem[lk_idx];
  end

  assign lk_cnt    = cnt_mem[lk_cidx];
  assign hit       = lk_ent.valid && (lk_ent.tag == BTB_TAG_MAX'(lk_tag)) &&
                     (lk_ent.br_type != BR_NONE);
  assign lookup_go = if_valid && (state_q == ST_IDLE);
  assign train     = vr.valid && (vr.br_type != BR_NONE);
  assign flush     = vr.valid && vr.mispredict && (state_q == ST_IDLE);
  assign restore   = flush || flush_all;

`ifdef BPU_GSHARE_EN
  logic [HIST_LEN-1:0] ghr_q;

  assign lk_cidx = lk_idx ^ IDX_W'(ghr_q);
  assign vr_cidx = vr_idx ^ IDX_W'(vr_ghr);
  assign cur_ghr = ghr_q;

  // A branch mispredict rebuilds history from the one carried with the branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (flush && (vr.br_type == BR_BRA)) begin
      ghr_q <= HIST_LEN'({vr_ghr, vr.taken});
    end else if (lookup_go && hit && (lk_ent.br_type == BR_BRA)) begin
      ghr_q <= HIST_LEN'({ghr_q, p_taken});
    end
  end
`else
  logic unused_vr_ghr;

  assign lk_cidx       = lk_idx;
  assign vr_cidx       = vr_idx;
  assign cur_ghr       = '0;
  assign unused_vr_ghr = ^vr_ghr;
`endif

  always_comb begin
    p_taken  = 1'b0;
    p_target = pc_plus8;
    if (hit) begin
      case (lk_ent.br_type)
        BR_BRA: begin
          p_taken = lk_cnt[1];
          if (lk_cnt[1]) p_target = lk_ent.target;
        end
        BR_J, BR_CALL: begin
          p_taken  = 1'b1;
          p_target = lk_ent.target;
        end
        BR_RET: begin
          if (!ras_empty) begin
            p_taken  = 1'b1;
            p_target = ras_top;
          end
        end
        default: ;
      endcase
    end
  end

  assign ras_push = lookup_go && hit && (lk_ent.br_type == BR_CALL) && !restore;
  assign ras_pop  = lookup_go && hit && (lk_ent.br_type == BR_RET) && !restore;

  bpu_param_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push        (ras_push),
    .pop         (ras_pop),
    .push_data   (pc_plus8),
    .commit_push (vr.valid && (vr.br_type == BR_CALL)),
    .commit_pop  (vr.valid && (vr.br_type == BR_RET)),
    .restore     (restore),
    .top         (ras_top),
    .empty       (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else if (train) valid_q[vr_idx] <= 1'b1;
  end

  // Writes land after the edge, so a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (train) begin
      tag_mem[vr_idx]  <= vr_tag;
      tgt_mem[vr_idx]  <= vr.target;
      type_mem[vr_idx] <= vr.br_type;
      cnt_mem[vr_cidx] <= cnt_next(vr.count, vr.taken, vr.mispredict);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid  <= 1'b0;
      pred_br_op  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_count  <= '0;
      pred_ghr    <= '0;
    end else begin
      pred_valid <= lookup_go;
      if (if_valid) begin
        pred_br_op  <= hit;
        pred_taken  <= p_taken;
        pred_target <= p_target;
        pred_count  <= lk_cnt;
        pred_ghr    <= cur_ghr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (vr.valid && vr.mispredict) state_d = ST_CORRECT;
      ST_CORRECT: if (correct_finish) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (flush_all) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      corr_target <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_CORRECT)) begin
      corr_target <= vr.taken ? vr.target : vr.pc + 32'd8;
    end
  end

  assign corr_valid = (state_q == ST_CORRECT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bpu_param.sv
// Directed bench for bpu_param: a table of per-cycle vectors plus short hand-built
// sequences for RAS, flush and redirect corner cases.
module tb_bpu_param;
  import bpu_param_pkg::*;

  localparam logic [2:0] T_NONE = 3'd0, T_BRA = 3'd1, T_J = 3'd2, T_CALL = 3'd3, T_RET = 3'd4;

  logic        clk = 1'b0;
  logic        reset, flush_all, correct_finish, if_valid;
  logic [31:0] if_pc;
  logic        pred_valid, pred_br_op, pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_count;
  logic [7:0]  pred_ghr;
  logic        vr_valid, vr_taken, vr_mispredict;
  logic [31:0] vr_pc, vr_target;
  logic [2:0]  vr_br_type;
  logic [1:0]  vr_count;
  logic [7:0]  vr_ghr;
  logic        flush, corr_valid;
  logic [31:0] corr_target;
  bpu_state_t  dbg_state;

  always #5 clk = ~clk;

  bpu_param dut (
    .clk(clk), .reset(reset), .flush_all(flush_all), .correct_finish(correct_finish),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_valid(pred_valid), .pred_br_op(pred_br_op), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_count(pred_count), .pred_ghr(pred_ghr),
    .vr_valid(vr_valid), .vr_pc(vr_pc), .vr_target(vr_target), .vr_br_type(vr_br_type),
    .vr_taken(vr_taken), .vr_mispredict(vr_mispredict), .vr_count(vr_count), .vr_ghr(vr_ghr),
    .flush(flush), .corr_valid(corr_valid), .corr_target(corr_target), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] ipc;
    logic        vv;
    logic [31:0] vpc;
    logic [31:0] vtgt;
    logic [2:0]  vty;
    logic        vtk;
    logic        vmis;
    logic [1:0]  vcnt;
    logic [7:0]  vghr;
    logic        fa;
    logic        cf;
    logic        e_pv;
    logic        e_op;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        chk_cnt;
    logic [1:0]  e_cnt;
    logic [7:0]  e_ghr;
    logic        e_flush;
    logic        e_corr;
    logic [31:0] e_ctgt;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  vec_t        tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t lk(input logic [31:0] pc, input logic op, input logic tk,
                              input logic [31:0] tgt);
    vec_t v;
    v = nop();
    v.iv = 1'b1; v.ipc = pc;
    v.e_pv = 1'b1; v.e_op = op; v.e_tk = tk; v.e_tgt = tgt;
    return v;
  endfunction

  function automatic vec_t lkc(input logic [31:0] pc, input logic op, input logic tk,
                               input logic [31:0] tgt, input logic [1:0] cnt);
    vec_t v;
    v = lk(pc, op, tk, tgt);
    v.chk_cnt = 1'b1; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t vr(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] ty,
                              input logic tk, input logic mis, input logic [1:0] cnt,
                              input logic ef);
    vec_t v;
    v = nop();
    v.vv = 1'b1; v.vpc = pc; v.vtgt = tgt; v.vty = ty;
    v.vtk = tk; v.vmis = mis; v.vcnt = cnt; v.e_flush = ef;
    return v;
  endfunction

  // Entered at a falling edge; drives one cycle and checks the registered results.
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] exp_t;
    if_valid = v.iv; if_pc = v.ipc;
    vr_valid = v.vv; vr_pc = v.vpc; vr_target = v.vtgt; vr_br_type = v.vty;
    vr_taken = v.vtk; vr_mispredict = v.vmis; vr_count = v.vcnt; vr_ghr = v.vghr;
    flush_all = v.fa; correct_finish = v.cf;
    if (v.e_pv) exp_q.push_back(v.e_tgt);
    #1;
    check({tag, ".flush"}, 32'(flush), 32'(v.e_flush));
    @(posedge clk);
    #1;
    check({tag, ".pred_valid"}, 32'(pred_valid), 32'(v.e_pv));
    if (v.e_pv) begin
      exp_t = exp_q.pop_front();
      check({tag, ".br_op"}, 32'(pred_br_op), 32'(v.e_op));
      check({tag, ".taken"}, 32'(pred_taken), 32'(v.e_tk));
      check({tag, ".target"}, pred_target, exp_t);
      check({tag, ".ghr"}, 32'(pred_ghr), 32'(v.e_ghr));
      if (v.chk_cnt) check({tag, ".count"}, 32'(pred_count), 32'(v.e_cnt));
    end
    check({tag, ".corr_valid"}, 32'(corr_valid), 32'(v.e_corr));
    check({tag, ".state"}, 32'(dbg_state), 32'(v.e_corr));
    if (v.e_corr) check({tag, ".corr_target"}, corr_target, v.e_ctgt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    if_valid = 1'b0; if_pc = '0; vr_valid = 1'b0; vr_pc = '0; vr_target = '0;
    vr_br_type = '0; vr_taken = 1'b0; vr_mispredict = 1'b0; vr_count = '0; vr_ghr = '0;
    flush_all = 1'b0; correct_finish = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset.pred_valid", 32'(pred_valid), 32'd0);
    check("reset.pred_target", pred_target, 32'd0);
    check("reset.corr_valid", 32'(corr_valid), 32'd0);
    check("reset.flush", 32'(flush), 32'd0);
    check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    vec_t t;

    do_reset();
`ifndef BPU_GSHARE_EN
    // Main table: cold miss, train, counter walk, saturation, tags, no-bypass.
    tab.push_back(lk(32'h8000_0100, 1'b0, 1'b0, 32'h8000_0108));
    t = vr(32'h8000_0100, 32'h8000_0200, T_BRA, 1'b1, 1'b1, 2'b01, 1'b1);
    t.e_corr = 1'b1; t.e_ctgt = 32'h8000_0200; tab.push_back(t);
    t = nop(); t.iv = 1'b1; t.ipc = 32'h8000_0100;
    t.e_corr = 1'b1; t.e_ctgt = 32'h8000_0200; tab.push_back(t);
    t = nop(); t.cf = 1'b1; tab.push_back(t);
    tab.push_back(lkc(32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200, 2'b10));
    tab.push_back(vr(32'h8000_0100, 32'h8000_0200, T_BRA, 1'b0, 1'b0, 2'b11, 1'b0));
    tab.push_back(lkc(32'h8000_0100, 1'b1, 1'b1, 32'h8000_0200, 2'b10));
    tab.push_back(vr(32'h8000_0100, 32'h8000_0200, T_BRA, 1'b0, 1'b0, 2'b10, 1'b0));
    tab.push_back(lkc(32'h8000_0100, 1'b1, 1'b0, 32'h8000_0108, 2'b01));
    tab.push_back(vr(32'h8000_0300, 32'h8000_0400, T_BRA, 1'b1, 1'b0, 2'b11, 1'b0));
    tab.push_back(lkc(32'h8000_0300, 1'b1, 1'b1, 32'h8000_0400, 2'b11));
    tab.push_back(vr(32'h8000_0300, 32'h8000_0400, T_BRA, 1'b0, 1'b0, 2'b00, 1'b0));
    tab.push_back(lkc(32'h8000_0300, 1'b1, 1'b0, 32'h8000_0308, 2'b00));
    tab.push_back(vr(32'h8000_0500, 32'h8000_1000, T_J, 1'b1, 1'b0, 2'b00, 1'b0));
    tab.push_back(lk(32'h8000_0500, 1'b1, 1'b1, 32'h8000_1000));
    tab.push_back(lk(32'h8000_1100, 1'b0, 1'b0, 32'h8000_1108));
    tab.push_back(vr(32'h8000_0600, 32'h0000_1234, T_NONE, 1'b1, 1'b0, 2'b00, 1'b0));
    tab.push_back(lk(32'h8000_0600, 1'b0, 1'b0, 32'h8000_0608));
    t = lk(32'h8000_0700, 1'b0, 1'b0, 32'h8000_0708);
    t.vv = 1'b1; t.vpc = 32'h8000_0700; t.vtgt = 32'h1234_5678; t.vty = T_J; t.vtk = 1'b1;
    tab.push_back(t);
    tab.push_back(lk(32'h8000_0700, 1'b1, 1'b1, 32'h1234_5678));
    t = vr(32'h8000_0300, 32'h8000_0400, T_BRA, 1'b0, 1'b1, 2'b11, 1'b1);
    t.e_corr = 1'b1; t.e_ctgt = 32'h8000_0308; tab.push_back(t);
    t = nop(); t.fa = 1'b1; tab.push_back(t);
    tab.push_back(lkc(32'h8000_0300, 1'b1, 1'b0, 32'h8000_0308, 2'b01));
    for (int i = 0; i < tab.size(); i++) apply(tab[i], $sformatf("main%0d", i));

    // RAS push on predicted CALL, pop on predicted RET, then empty.
    do_reset();
    apply(vr(32'h0000_1000, 32'h0000_2000, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0), "ras_tc");
    apply(vr(32'h0000_2044, 32'h0000_1008, T_RET, 1'b1, 1'b0, 2'b00, 1'b0), "ras_tr");
    apply(lk(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000), "ras_call");
    apply(lk(32'h0000_2044, 1'b1, 1'b1, 32'h0000_1008), "ras_ret");
    apply(lk(32'h0000_2044, 1'b1, 1'b0, 32'h0000_204C), "ras_empty");

    // Nine calls into an eight-deep stack: oldest lost, eight pops then empty.
    do_reset();
    apply(vr(32'h0000_2044, 32'h0000_1008, T_RET, 1'b1, 1'b0, 2'b00, 1'b0), "ovf_tr");
    for (int k = 0; k < 9; k++)
      apply(vr(32'h0000_1000 + 32'(16 * k), 32'h0000_3000, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0),
            $sformatf("ovf_tc%0d", k));
    for (int k = 0; k < 9; k++)
      apply(lk(32'h0000_1000 + 32'(16 * k), 1'b1, 1'b1, 32'h0000_3000), $sformatf("ovf_call%0d", k));
    for (int k = 8; k >= 1; k--)
      apply(lk(32'h0000_2044, 1'b1, 1'b1, 32'h0000_1008 + 32'(16 * k)), $sformatf("ovf_pop%0d", k));
    apply(lk(32'h0000_2044, 1'b1, 1'b0, 32'h0000_204C), "ovf_empty");

    // Mispredict together with flush_all: stay IDLE, speculative RAS rolls back.
    do_reset();
    apply(vr(32'h0000_2044, 32'h0000_1008, T_RET, 1'b1, 1'b0, 2'b00, 1'b0), "fa_tr");
    apply(vr(32'h0000_1000, 32'h0000_2000, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0), "fa_tc");
    apply(lk(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000), "fa_call0");
    apply(lk(32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000), "fa_call1");
    t = vr(32'h8000_0800, 32'h8000_0900, T_BRA, 1'b1, 1'b1, 2'b01, 1'b1);
    t.fa = 1'b1;
    apply(t, "fa_both");
    apply(lk(32'h0000_2044, 1'b1, 1'b1, 32'h0000_1008), "fa_ret");
    apply(lk(32'h0000_2044, 1'b1, 1'b0, 32'h0000_204C), "fa_empty");

    // Second mispredict while correcting: ignored by the FSM, still trains.
    do_reset();
    t = vr(32'h0000_4000, 32'h0000_5000, T_BRA, 1'b1, 1'b1, 2'b01, 1'b1);
    t.e_corr = 1'b1; t.e_ctgt = 32'h0000_5000;
    apply(t, "cc_first");
    t = vr(32'h0000_6010, 32'h0000_7000, T_J, 1'b1, 1'b1, 2'b00, 1'b0);
    t.e_corr = 1'b1; t.e_ctgt = 32'h0000_5000;
    apply(t, "cc_second");
    t = nop(); t.cf = 1'b1;
    apply(t, "cc_finish");
    apply(lk(32'h0000_6010, 1'b1, 1'b1, 32'h0000_7000), "cc_j");
    apply(lkc(32'h0000_4000, 1'b1, 1'b1, 32'h0000_5000, 2'b10), "cc_bra");
`else
    // Same PC under different history hits different counters; mispredict rebuilds history.
    t = vr(32'h0000_0100, 32'h0000_0200, T_BRA, 1'b1, 1'b0, 2'b11, 1'b0);
    apply(t, "gs_t0");
    t = vr(32'h0000_0100, 32'h0000_0200, T_BRA, 1'b0, 1'b0, 2'b00, 1'b0);
    t.vghr = 8'h01;
    apply(t, "gs_t1");
    t = vr(32'h0000_0100, 32'h0000_0200, T_BRA, 1'b1, 1'b0, 2'b11, 1'b0);
    t.vghr = 8'h0B;
    apply(t, "gs_t2");
    apply(lkc(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 2'b11), "gs_l0");
    t = lkc(32'h0000_0100, 1'b1, 1'b0, 32'h0000_0108, 2'b00);
    t.e_ghr = 8'h01;
    apply(t, "gs_l1");
    t = vr(32'h0000_0100, 32'h0000_0200, T_BRA, 1'b1, 1'b1, 2'b01, 1'b1);
    t.vghr = 8'h05; t.e_corr = 1'b1; t.e_ctgt = 32'h0000_0200;
    apply(t, "gs_mis");
    t = nop(); t.cf = 1'b1;
    apply(t, "gs_finish");
    t = lkc(32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200, 2'b11);
    t.e_ghr = 8'h0B;
    apply(t, "gs_l2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
